microbot_move_scheduler: RTL and testbench
==========================================

// Module: microbot_move_scheduler
// PURPOSE
//   Move-command scheduler for the microbot controller datapath inside tt_um_controlador_microbots.
//   Accepts 8-bit move commands from the pin-decode logic and buffers them in a small FIFO.
//   Executes one command at a time: drives the two motor enable/direction pairs for a timed duration,
//   then inserts a motors-off dead time before the next command.
// PARAMETERS
//   DEPTH     4     FIFO entries; power of 2, >= 2
//   TICK_DIV  1000  clk cycles per duration unit; >= 2
//   DEAD      16    motors-off cycles between commands; >= 1
// PORTS
//   clk         in   1  clock
//   rst_n       in   1  reset; synchronous, active-low
//   ena         in   1  design enable; low = pause execution
//   cmd_valid   in   1  command strobe
//   cmd_data    in   8  [7:6] dir code, [5:0] duration in ticks
//   cmd_ready   out  1  FIFO can accept (= !full)
//   abort       in   1  flush queue and stop motors
//   motor_en    out  2  {left,right} motor enable
//   motor_dir   out  2  {left,right} direction; 1 = reverse
//   busy        out  1  state != IDLE or FIFO not empty
//   fifo_count  out  $clog2(DEPTH)+1  entries queued
// BEHAVIOUR
//   Reset (rst_n low at posedge):
//   - FIFO empty; state IDLE; all counters 0.
//   - motor_en=0, motor_dir=0, busy=0, fifo_count=0, cmd_ready=1.
//   Push and pop:
//   - Push on posedge when cmd_valid & cmd_ready.
//   - Simultaneous push and pop is legal and leaves fifo_count unchanged.
//   - Push while full is impossible (cmd_ready=0); cmd_valid is ignored.
//   - Pointers wrap modulo DEPTH.
//   Dir codes (motor_en/motor_dir):
//   - 00 fwd: en=11, dir=00
//   - 01 rev: en=11, dir=11
//   - 10 left: en=11, dir=10
//   - 11 right: en=11, dir=01
//   FSM IDLE / RUN / DEAD, all outputs registered:
//   - IDLE: if FIFO not empty, pop at this edge and latch dir and dur.
//     - dur != 0: go to RUN, with motor_en/dir valid from the next cycle.
//     - dur == 0: go to DEAD (no drive).
//   - RUN: motors driven for exactly dur*TICK_DIV cycles.
//     - Tick counter counts TICK_DIV-1 down to 0; at 0 it reloads and dur decrements.
//     - When the last tick expires: motor_en=0 on the next cycle, go to DEAD.
//   - DEAD: motor_en=0 for exactly DEAD cycles, then IDLE.
//     - IDLE spends >= 1 cycle before the next pop.
//   Latency: push at edge N into an empty, idle block gives pop at edge N+1 and motor_en=11 after edge N+1.
//   abort (priority just below reset), sampled at posedge:
//   - FIFO flushed (count=0); any cmd_valid in the same cycle is dropped.
//   - From RUN: motor_en=0 next cycle, state DEAD with full DEAD count.
//   - From DEAD: dead count restarts.
//   - From IDLE: stays IDLE.
//   ena low:
//   - FSM and counters hold; no pops.
//   - motor_en forced to 00 combinationally in the same cycle.
//   - FIFO pushes still accepted; abort still honoured.
//   - On ena high, execution resumes with the remaining time intact.
//   Reset mid-command: the next edge with rst_n low stops the motors and clears everything, per the reset values above.
//   Counter widths: dur counter 6 bits; tick counter $clog2(TICK_DIV) bits; dead counter $clog2(DEAD+1) bits.
// TESTING  (bench uses TICK_DIV=4, DEAD=2, DEPTH=4)
//   1. Reset, push 0x03 (fwd, dur 3) -> motor_en=11, dir=00 for exactly 12 cycles starting 2 cycles after push;
//      then 0 for 2 cycles; busy=0 after that.
//   2. Push 0x41,0x81,0xC1,0x01,0x01 back-to-back -> cmd_ready drops when count=4;
//      the 5th is held until a pop; drive order is rev, left, right, fwd, fwd, each 4 cycles with 2 dead cycles between.
//   3. Push 0x00 -> no motor_en pulse; DEAD for 2 cycles, then IDLE.
//   4. Push 0x3F, then after 10 drive cycles assert abort for 1 cycle with 2 queued entries and cmd_valid=1
//      -> motor_en=0 next cycle, fifo_count=0, new command not stored.
//   5. Push 0x02 and drop ena for 5 cycles mid-RUN -> motor_en=0 during the pause;
//      total driven cycles still 8; a push during the pause is accepted.
//   6. Assert rst_n=0 mid-RUN with a 3-deep queue -> all outputs at reset values after that edge;
//      cmd_ready=1, fifo_count=0.

Source files
------------

// File: rtl/microbot_move_scheduler.sv
// Move-command scheduler: FIFO-buffered 8-bit commands drive two motors for dur*TICK_DIV cycles, then DEAD off cycles.
// Latency: push into an idle, empty block pops on the next edge. Backpressure: cmd_ready low while the FIFO is full.
module microbot_move_scheduler #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 1000,
  parameter int DEAD     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     cmd_valid,
  input  logic [7:0]               cmd_data,
  output logic                     cmd_ready,
  input  logic                     abort,
  output logic [1:0]               motor_en,
  output logic [1:0]               motor_dir,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEAD + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t        r_state;
  logic [5:0]    r_dur;
  logic [TW-1:0] r_tick;
  logic [DW-1:0] r_dead;
  logic [1:0]    r_en;
  logic [1:0]    r_dir;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [1:0]    w_head_dir;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // abort wins over any same-cycle push or pop
  assign w_push  = cmd_valid & ~w_full & ~abort;
  assign w_pop   = ena & (r_state == S_IDLE) & ~w_empty & ~abort;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_head_dir = 2'b00;
    case (w_head[7:6])
      2'b00:   w_head_dir = 2'b00;
      2'b01:   w_head_dir = 2'b11;
      2'b10:   w_head_dir = 2'b10;
      default: w_head_dir = 2'b01;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dur   <= '0;
      r_tick  <= '0;
      r_dead  <= '0;
      r_en    <= 2'b00;
      r_dir   <= 2'b00;
    end else if (abort) begin
      r_en  <= 2'b00;
      r_dir <= 2'b00;
      if (r_state != S_IDLE) begin
        r_state <= S_DEAD;
        r_dead  <= DW'(DEAD);
      end
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_dur  <= w_head[5:0];
            r_tick <= TW'(TICK_DIV - 1);
            if (w_head[5:0] != 6'd0) begin
              r_state <= S_RUN;
              r_en    <= 2'b11;
              r_dir   <= w_head_dir;
            end else begin
              r_state <= S_DEAD;
              r_dead  <= DW'(DEAD);
            end
          end
        end
        S_RUN: begin
          if (r_tick == '0) begin
            if (r_dur == 6'd1) begin
              r_state <= S_DEAD;
              r_dead  <= DW'(DEAD);
              r_en    <= 2'b00;
              r_dir   <= 2'b00;
            end else begin
              r_dur  <= r_dur - 6'd1;
              r_tick <= TW'(TICK_DIV - 1);
            end
          end else begin
            r_tick <= r_tick - 1'b1;
          end
        end
        S_DEAD: begin
          // last dead cycle hands over to IDLE, which waits one cycle before popping
          if (r_dead <= DW'(1)) r_state <= S_IDLE;
          else                  r_dead  <= r_dead - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // pausing must silence the motors without waiting for a clock edge
  assign motor_en   = r_en & {2{ena}};
  assign motor_dir  = r_dir;
  assign busy       = (r_state != S_IDLE) | ~w_empty;
  assign fifo_count = r_count;
  assign cmd_ready  = ~w_full;

endmodule

// File: tb/tb_microbot_move_scheduler.sv
// Bench for microbot_move_scheduler: expected motor pulses are queued at push time and
// compared against pulses observed on motor_en/motor_dir.
module tb_microbot_move_scheduler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       abort;
  logic [1:0] motor_en;
  logic [1:0] motor_dir;
  logic       busy;
  logic [2:0] fifo_count;

  microbot_move_scheduler #(.DEPTH(4), .TICK_DIV(4), .DEAD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .motor_en   (motor_en),
    .motor_dir  (motor_dir),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int en;
    int dir;
    int len;
    int gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b1;
  bit   in_pulse = 1'b0;
  int   p_len = 0;
  int   p_en = 0;
  int   p_dir = 0;
  int   off_cnt = 0;

  task automatic chk_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic exp_add(input int en, input int dir, input int len, input int gap);
    exp_t x;
    x.en = en; x.dir = dir; x.len = len; x.gap = gap;
    sb.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    while (!cmd_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!cmd_ready) chk_eq("push_timeout", 0, 1);
    else            cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    chk_eq("idle_reached", busy, 0);
    cyc(1);
  endtask

  // Pulse monitor: length and gap count only cycles with ena high.
  always @(negedge clk) begin
    if (mon_on && rst_n && ena) begin
      if (motor_en != 2'b00) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          p_len = 0;
          p_en  = motor_en;
          p_dir = motor_dir;
          if (sb.size() > 0 && sb[0].gap >= 0) chk_eq("pulse_gap", off_cnt, sb[0].gap);
        end
        p_len++;
      end else begin
        if (in_pulse) begin
          in_pulse = 1'b0;
          off_cnt = 0;
          if (sb.size() == 0) chk_eq("unexpected_pulse_len", p_len, 0);
          else begin
            e = sb.pop_front();
            chk_eq("pulse_en", p_en, e.en);
            chk_eq("pulse_dir", p_dir, e.dir);
            chk_eq("pulse_len", p_len, e.len);
          end
        end
        off_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; abort = 1'b0;
    cyc(2);
    chk_eq("rst_motor_en", motor_en, 0);
    chk_eq("rst_motor_dir", motor_dir, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_fifo_count", fifo_count, 0);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    cyc(1);

    // 1: single forward command, dur 3
    exp_add(3, 0, 12, -1);
    push_cmd(8'h03);
    chk_eq("t1_count_after_push", fifo_count, 1);
    chk_eq("t1_en_not_yet", motor_en, 0);
    cyc(1);
    chk_eq("t1_en_on", motor_en, 3);
    chk_eq("t1_dir_fwd", motor_dir, 0);
    chk_eq("t1_popped", fifo_count, 0);
    wait_idle(100);

    // 2: fill the FIFO while paused, hold the 5th push, then drain in order
    ena = 1'b0;
    push_cmd(8'h41);
    push_cmd(8'h81);
    push_cmd(8'hC1);
    push_cmd(8'h01);
    chk_eq("t2_full_count", fifo_count, 4);
    chk_eq("t2_full_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_data = 8'h01;
    cyc(2);
    chk_eq("t2_held_count", fifo_count, 4);
    exp_add(3, 3, 4, -1);
    exp_add(3, 2, 4, 3);
    exp_add(3, 1, 4, 3);
    exp_add(3, 0, 4, 3);
    exp_add(3, 0, 4, 3);
    ena = 1'b1;
    cyc(1);
    chk_eq("t2_after_pop_count", fifo_count, 3);
    chk_eq("t2_after_pop_ready", cmd_ready, 1);
    cyc(1);
    cmd_valid = 1'b0;
    chk_eq("t2_fifth_accepted", fifo_count, 4);
    wait_idle(200);

    // 3: zero-duration command: dead time only
    push_cmd(8'h00);
    cyc(1);
    chk_eq("t3_no_drive", motor_en, 0);
    chk_eq("t3_busy_dead1", busy, 1);
    cyc(1);
    chk_eq("t3_busy_dead2", busy, 1);
    cyc(1);
    chk_eq("t3_idle", busy, 0);
    cyc(2);

    // 4: abort after 10 drive cycles with two entries queued and a push pending
    exp_add(3, 0, 10, -1);
    push_cmd(8'h3F);
    push_cmd(8'h01);
    push_cmd(8'h02);
    chk_eq("t4_queued", fifo_count, 2);
    cyc(8);
    abort = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h40;
    cyc(1);
    abort = 1'b0; cmd_valid = 1'b0;
    chk_eq("t4_abort_en", motor_en, 0);
    chk_eq("t4_abort_count", fifo_count, 0);
    chk_eq("t4_abort_busy_dead", busy, 1);
    wait_idle(50);
    chk_eq("t4_nothing_stored", fifo_count, 0);

    // 5: pause mid-run for 5 cycles, push during the pause
    exp_add(3, 0, 8, -1);
    push_cmd(8'h02);
    cyc(3);
    ena = 1'b0;
    #1;
    chk_eq("t5_pause_en_comb", motor_en, 0);
    push_cmd(8'h00);
    cyc(4);
    chk_eq("t5_pause_push", fifo_count, 1);
    chk_eq("t5_pause_en", motor_en, 0);
    ena = 1'b1;
    #1;
    chk_eq("t5_resume_en", motor_en, 3);
    wait_idle(200);
    chk_eq("t5_drained", fifo_count, 0);

    // 6: reset mid-run with a 3-deep queue
    mon_on = 1'b0;
    push_cmd(8'h45);
    push_cmd(8'h01);
    push_cmd(8'h02);
    push_cmd(8'h03);
    cyc(2);
    chk_eq("t6_queued", fifo_count, 3);
    chk_eq("t6_running_en", motor_en, 3);
    chk_eq("t6_running_dir", motor_dir, 3);
    rst_n = 1'b0;
    cyc(1);
    chk_eq("t6_rst_en", motor_en, 0);
    chk_eq("t6_rst_dir", motor_dir, 0);
    chk_eq("t6_rst_busy", busy, 0);
    chk_eq("t6_rst_count", fifo_count, 0);
    chk_eq("t6_rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    cyc(3);
    chk_eq("t6_stays_idle", busy, 0);
    chk_eq("t6_stays_off", motor_en, 0);

    chk_eq("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
